// File: rtl/spike_rate_monitor.sv
// Spike rate / inter-spike interval monitor for the QIF neuron spike line.
// Counts rising edges per fixed window and measures cycles between edges.
module spike_rate_monitor #(
  parameter int unsigned WINDOW = 10_000_000,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ISI_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             busy
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s_q, s_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic             spk_ovf_q, spk_ovf_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic             rate_sat_q, rate_sat_d;
  logic             rate_valid_q, rate_valid_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d;
  logic             isi_valid_q, isi_valid_d;
  logic             busy_q, busy_d;
  logic             rise_c;

  assign rise_c = spike_in & ~s_q;

  // Next-state, counters and result capture
  always_comb begin
    logic             spk_full;
    logic             ovf_now;
    logic [CNT_W-1:0] spk_inc;

    state_d      = state_q;
    s_d          = spike_in;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    spk_ovf_d    = spk_ovf_q;
    isi_cnt_d    = isi_cnt_q;
    rate_out_d   = rate_out_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = 1'b0;
    isi_out_d    = isi_out_q;
    isi_valid_d  = 1'b0;

    spk_full = (spk_cnt_q == CNT_MAX);
    ovf_now  = spk_ovf_q | (spk_full & rise_c);
    spk_inc  = spk_full ? CNT_MAX : spk_cnt_q + CNT_W'(rise_c);

    if (!en) begin
      state_d   = S_IDLE;
      win_cnt_d = '0;
      spk_cnt_d = '0;
      spk_ovf_d = 1'b0;
      isi_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_FIRST;
          win_cnt_d = '0;
          spk_cnt_d = '0;
          spk_ovf_d = 1'b0;
          isi_cnt_d = '0;
        end
        S_FIRST, S_RUN: begin
          // Interval measurement; the first edge after enable only arms it
          if (rise_c) begin
            if (state_q == S_RUN) begin
              isi_out_d   = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
              isi_valid_d = 1'b1;
            end
            isi_cnt_d = '0;
            state_d   = S_RUN;
          end else if ((state_q == S_RUN) && (isi_cnt_q != ISI_MAX)) begin
            isi_cnt_d = isi_cnt_q + ISI_W'(1);
          end
          // Window: an edge on the last cycle belongs to the closing window
          if (win_cnt_q == WIN_LAST) begin
            rate_out_d   = spk_inc;
            rate_sat_d   = ovf_now;
            rate_valid_d = 1'b1;
            spk_cnt_d    = '0;
            spk_ovf_d    = 1'b0;
            win_cnt_d    = '0;
          end else begin
            spk_cnt_d = spk_inc;
            spk_ovf_d = ovf_now;
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      s_q          <= 1'b0;
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      spk_ovf_q    <= 1'b0;
      isi_cnt_q    <= '0;
      rate_out_q   <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_out_q    <= '0;
      isi_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      spk_ovf_q    <= spk_ovf_d;
      isi_cnt_q    <= isi_cnt_d;
      rate_out_q   <= rate_out_d;
      rate_sat_q   <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      isi_out_q    <= isi_out_d;
      isi_valid_q  <= isi_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign rate_out   = rate_out_q;
  assign rate_sat   = rate_sat_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_out_q;
  assign isi_valid  = isi_valid_q;
  assign busy       = busy_q;

endmodule
